auv_wb_arbiter: RTL



---
 rtl/auv_wb_arbiter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/auv_wb_arbiter.sv
// auv_wb_arbiter
// Two-master, one-slave arbiter for the core's 16-bit pipelined Wishbone bus.
// Master 0 is instruction fetch and master 1 is the execute-stage load/store
// port. The grant is held for a whole bus cycle (cyc), so a two-strobe word
// access from master 1 is never split by a fetch. Outstanding strobes are
// counted, and hung transfers are aborted with a timeout error.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   mN_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i   master N request (N = 0, 1)
//   mN_dat_o            slave read data, broadcast to both masters
//   mN_ack_o/err_o/stall_o                  master N response
//   s_adr_o/dat_o/sel_o/we_o/stb_o/cyc_o    owner's request toward the slave
//   s_dat_i, s_ack_i, s_err_i, s_stall_i    slave response
//   dbg_state           current arbiter state (0 IDLE, 1 OWN0, 2 OWN1)
//
// Handshake: a strobe is transferred on a cycle where s_stb_o is high and
// s_stall_i is low (stb is "valid", ~stall is "ready"); each transferred
// strobe is later retired by exactly one s_ack_i or s_err_i cycle.
module auv_wb_arbiter #(
  parameter int ADDR_WIDTH = 24,
  parameter int MAX_OUTST  = 2,
  parameter int TIMEOUT    = 255,
  parameter int PRIO_M1    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [15:0]           m0_dat_i,
  input  logic [1:0]            m0_sel_i,
  input  logic                  m0_we_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  output logic [15:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_stall_o,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [15:0]           m1_dat_i,
  input  logic [1:0]            m1_sel_i,
  input  logic                  m1_we_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  output logic [15:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_stall_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [15:0]           s_dat_o,
  output logic [1:0]            s_sel_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  input  logic [15:0]           s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_stall_i,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] MAX_O    = 2'(MAX_OUTST);
  localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);
  localparam bit         TMO_EN   = (TIMEOUT != 0);

  state_t     state, state_n;
  logic [1:0] outst, outst_n;
  logic [7:0] tmr, tmr_n;
  logic       last, last_n;

  // Combinational view of the current owner and its request.
  logic                  owner_vld, owner;
  logic [ADDR_WIDTH-1:0] o_adr;
  logic [15:0]           o_dat;
  logic [1:0]            o_sel;
  logic                  o_we, o_stb, o_cyc;
  logic                  busy, full, rsp, tmo, accept;
  logic                  s_cyc_c, s_stb_c;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign dbg_state = state;

  always_comb begin
    owner_vld  = 1'b0;
    owner      = 1'b0;
    state_n    = state;
    last_n     = last;
    outst_n    = outst;
    tmr_n      = tmr;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    s_we_o     = 1'b0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;

    // Arbitration in IDLE is combinational so the winner reaches the slave
    // in the same cycle; in OWNn the grant is simply held.
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_vld = 1'b1;
          owner     = (PRIO_M1 != 0) ? 1'b1 : ~last;
        end else if (m1_cyc_i) begin
          owner_vld = 1'b1;
          owner     = 1'b1;
        end else if (m0_cyc_i) begin
          owner_vld = 1'b1;
          owner     = 1'b0;
        end
      end
      OWN0: begin
        owner_vld = 1'b1;
        owner     = 1'b0;
      end
      OWN1: begin
        owner_vld = 1'b1;
        owner     = 1'b1;
      end
      default: begin
        owner_vld = 1'b0;
        owner     = 1'b0;
      end
    endcase

    o_adr = owner ? m1_adr_i : m0_adr_i;
    o_dat = owner ? m1_dat_i : m0_dat_i;
    o_sel = owner ? m1_sel_i : m0_sel_i;
    o_we  = owner ? m1_we_i  : m0_we_i;
    o_stb = owner ? m1_stb_i : m0_stb_i;
    o_cyc = owner ? m1_cyc_i : m0_cyc_i;

    busy = (outst != 2'd0);
    full = (outst == MAX_O);
    // Responses with nothing outstanding are stray (late after a timeout or
    // reset) and must neither be routed nor disturb the counter.
    rsp  = (s_ack_i | s_err_i) & busy;
    tmo  = TMO_EN && busy && (tmr == TMR_LAST) && !(s_ack_i || s_err_i);

    // The bus cycle stays open while the owner holds cyc or responses are
    // still owed, even if the owner has already dropped cyc.
    s_cyc_c = owner_vld && (o_cyc || busy) && !tmo;
    s_stb_c = s_cyc_c && o_cyc && o_stb && !full;
    accept  = s_stb_c && !s_stall_i;

    if (owner_vld) begin
      s_adr_o = o_adr;
      s_dat_o = o_dat;
      s_sel_o = o_sel;
      s_we_o  = o_we;
    end
    s_cyc_o = s_cyc_c;
    s_stb_o = s_stb_c;

    if (owner_vld && !owner) begin
      m0_stall_o = s_stall_i | full;
      m0_ack_o   = s_ack_i & busy;
      m0_err_o   = (s_err_i & busy) | tmo;
    end
    if (owner_vld && owner) begin
      m1_stall_o = s_stall_i | full;
      m1_ack_o   = s_ack_i & busy;
      m1_err_o   = (s_err_i & busy) | tmo;
    end

    if (accept && !rsp) begin
      outst_n = outst + 2'd1;
    end else if (!accept && rsp) begin
      outst_n = outst - 2'd1;
    end

    if (!TMO_EN || !busy || s_ack_i || s_err_i) begin
      tmr_n = 8'd0;
    end else begin
      tmr_n = tmr + 8'd1;
    end

    if (state == IDLE) begin
      if (owner_vld) begin
        state_n = owner ? OWN1 : OWN0;
        last_n  = owner;
      end
    end else if (tmo) begin
      state_n = IDLE;
      outst_n = 2'd0;
      tmr_n   = 8'd0;
    end else if (!o_cyc && !busy) begin
      // Release cycle: s_cyc_o is already low; re-arbitration happens in
      // IDLE, which costs exactly one dead cycle per handover.
      state_n = IDLE;
    end

    // Reset forces a quiet bus regardless of the (possibly unknown) state.
    if (!rst_n) begin
      s_adr_o    = '0;
      s_dat_o    = '0;
      s_sel_o    = '0;
      s_we_o     = 1'b0;
      s_stb_o    = 1'b0;
      s_cyc_o    = 1'b0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_stall_o = 1'b1;
      m1_ack_o   = 1'b0;
      m1_err_o   = 1'b0;
      m1_stall_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      outst <= 2'd0;
      tmr   <= 8'd0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      outst <= outst_n;
      tmr   <= tmr_n;
      last  <= last_n;
    end
  end

endmodule
